// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and width helpers for the FIFO push arbiter
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Width of a producer index; never narrower than one bit.
    function automatic int grant_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Width of a counter that must hold values 0..max_burst.
    function automatic int burst_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - round-robin next-requester search, purely combinational
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GRANT_W = grant_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] lastGrant,
    output logic               anyReq,
    output logic [GRANT_W-1:0] nextId
);

    logic               found;
    int                 idx;
    logic [GRANT_W-1:0] cand;

    // Walk lastGrant+1, lastGrant+2, ... modulo NUM_REQ and take the first requester.
    always_comb begin
        anyReq = |req;
        nextId = '0;
        found  = 1'b0;
        idx    = 0;
        cand   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx  = (int'(lastGrant) + off) % NUM_REQ;
            cand = GRANT_W'(idx);
            if (!found && req[cand]) begin
                found  = 1'b1;
                nextId = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// rtl/fifo_push_arbiter.sv - round-robin arbiter sharing one FIFO push port among producers
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int  NUM_REQ   = 4,
    parameter int  DATA_SIZE = 8,
    parameter int  MAX_BURST = 4,
    localparam int GRANT_W   = grant_width(NUM_REQ),
    localparam int BURST_W   = burst_width(MAX_BURST)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_SIZE-1:0] reqData,
    output logic [NUM_REQ-1:0]           ack,
    input  logic                         fifoFull,
    output logic                         push,
    output logic [DATA_SIZE-1:0]         writeData,
    output logic                         grantValid,
    output logic [GRANT_W-1:0]           grantId
);

    arb_state_e         state_q, state_d;
    logic [GRANT_W-1:0] grant_id_q, grant_id_d;
    logic [GRANT_W-1:0] last_grant_q, last_grant_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;

    logic               any_req;
    logic [GRANT_W-1:0] next_id;
    logic               sel_req;
    logic [DATA_SIZE-1:0] sel_data;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .GRANT_W (GRANT_W)
    ) u_picker (
        .req       (req),
        .lastGrant (last_grant_q),
        .anyReq    (any_req),
        .nextId    (next_id)
    );

    // Select the granted producer's request bit and word.
    always_comb begin
        sel_req  = 1'b0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == GRANT_W'(i)) begin
                sel_req  = req[i];
                sel_data = reqData[i*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    // FIFO-facing outputs track the live fifoFull so a full FIFO is never pushed.
    always_comb begin
        grantValid = (state_q == GRANT);
        grantId    = grant_id_q;
        push       = grantValid & sel_req & ~fifoFull;
        writeData  = grantValid ? sel_data : '0;
        ack        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ack[i] = push & (grant_id_q == GRANT_W'(i));
        end
    end

    // Next-state: grant in IDLE, release on dropped request or completed burst.
    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_id_d  = next_id;
                    burst_cnt_d = '0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (!sel_req) begin
                    state_d      = IDLE;
                    last_grant_d = grant_id_q;
                    burst_cnt_d  = '0;
                end else if (push) begin
                    if (burst_cnt_q == BURST_W'(MAX_BURST - 1)) begin
                        state_d      = IDLE;
                        last_grant_d = grant_id_q;
                        burst_cnt_d  = '0;
                    end else begin
                        burst_cnt_d = burst_cnt_q + BURST_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; lastGrant resets to the top index so producer 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_id_q   <= '0;
            last_grant_q <= GRANT_W'(NUM_REQ - 1);
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

endmodule

// File: doc/fifo_push_arbiter.md
Name: fifo_push_arbiter

Overview:
Round-robin arbiter that shares the single push port of the team's FIFO between NUM_REQ producers. It grants one producer at a time and forwards that producer's words to the FIFO while the FIFO is not full. A burst limit bounds how long one producer may hold the port. The block sits directly in front of the FIFO: push/writeData drive it, and fifoFull is its full flag.

Parameters:
NUM_REQ, 4, number of producers; must be >= 2.
DATA_SIZE, 8, word width; must equal the FIFO's DATA_SIZE.
MAX_BURST, 4, maximum words pushed per grant; must be >= 1.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
req  input  NUM_REQ  per-producer request; bit i high means producer i has a valid word.
reqData  input  NUM_REQ*DATA_SIZE  producer i's word on bits [i*DATA_SIZE +: DATA_SIZE].
ack  output  NUM_REQ  one-hot pulse; bit i high means producer i's word is accepted this cycle.
fifoFull  input  1  FIFO full flag.
push  output  1  FIFO push strobe.
writeData  output  DATA_SIZE  word presented to the FIFO.
grantValid  output  1  a producer currently holds the grant.
grantId  output  GRANT_W  index of the granted producer; GRANT_W = $clog2(NUM_REQ).

Behaviour:
- Registered state: state (IDLE/GRANT), grantId, lastGrant (GRANT_W), burstCnt (BURST_W = $clog2(MAX_BURST+1)).
- grantValid = (state == GRANT).
- Outputs are combinational from registered state plus inputs, so the FIFO sees the current fifoFull with no overflow lag:
  - push = grantValid & req[grantId] & ~fifoFull.
  - writeData = reqData slice selected by grantId, or 0 when grantValid = 0.
  - ack = push ? one-hot(grantId) : 0.
- Reset (async, immediate):
  - state = IDLE, grantId = 0, lastGrant = NUM_REQ-1, burstCnt = 0.
  - push, ack and writeData go to 0 in the same cycle as rst asserts.
  - First arbitration after reset favours producer 0.
- IDLE:
  - If |req, grantId <= first set bit searching lastGrant+1, lastGrant+2, ... modulo NUM_REQ; burstCnt <= 0; go to GRANT.
  - Otherwise stay in IDLE.
  - No push is ever issued in IDLE, so there is a one-cycle bubble per grant change.
- GRANT:
  - On each push, burstCnt increments.
  - Release to IDLE (lastGrant <= grantId, burstCnt <= 0) when either:
    - req[grantId] = 0, or
    - push and burstCnt == MAX_BURST-1; the final word is still pushed in that cycle.
  - fifoFull = 1 with req held: no push, no ack, burstCnt frozen, grant held. Full does not release the grant.
  - Requests from other producers never preempt the current grant.
- Producer protocol:
  - Hold req and reqData stable until ack.
  - After ack, the next word may be presented in the following cycle.
  - Dropping req without ack is legal; it releases the grant and loses no data.
- Latency: req rising in IDLE gives a first push 1 cycle later (FIFO not full). Steady state is 1 word/clk up to MAX_BURST per grant.
- Throughput: MAX_BURST words per MAX_BURST+1 cycles under contention.
- Wrap-around: the round-robin search wraps from NUM_REQ-1 to 0. lastGrant = NUM_REQ-1 searches starting at 0.
- Single requester: it is regranted after each one-cycle IDLE bubble.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - state encoding (IDLE = 1'b0, GRANT = 1'b1);
  - width helper functions for GRANT_W and BURST_W.
- Natural sub-module rr_priority_picker:
  - purely combinational;
  - inputs req vector and lastGrant; outputs anyReq and nextId;
  - reusable for a future pop-side scheduler.
- Remaining FSM and muxing stay in fifo_push_arbiter, approx 150-250 lines RTL.

Test Plan:
1. Reset release, req=4'b0001 held, reqData0 counting 0x10.. -> grant to 0 at cycle 1. Pushes 0x10..0x13 on cycles 1-4, burst ends, IDLE at cycle 5, regrant cycle 6.
2. req=4'b1111 held, MAX_BURST=4, fifoFull=0 -> grant order 0,1,2,3,0. Each grant gives exactly 4 ack pulses to that producer, with 1 idle cycle between grants.
3. Producer 2 granted, fifoFull=1 for 3 cycles mid-burst -> push=0 and ack=0 for those 3 cycles; grantId stays 2; burstCnt unchanged. Pushes resume when full clears; total still 4 words.
4. Producer 1 granted, drops req after 2 acks -> release next edge with lastGrant=1. With req=4'b1001 pending, next grant goes to 3, not 0.
5. rst asserted mid-burst asynchronously (between edges) -> push, ack, writeData and grantValid go to 0 before the next edge. After release, producer 0 wins first.
6. Scoreboard: random req/fifoFull over 10k cycles with a FIFO model -> no push while fifoFull=1, ack always one-hot and equal to push, and per-producer data order preserved.
